tc_sm_stream: RTL and testbench
===============================

// Module: tc_sm_stream
// PURPOSE
//  Parametrised, pipelined two's-complement to sign-magnitude converter with a
//  valid/ready stream interface. Successor to the fixed 12-bit combinational
//  converter at the front of the linear-to-float path. Adds configurable width,
//  selectable most-negative handling, back-pressure, and a saturation event counter.
// PARAMETERS
//  W      12  input word width, W >= 2; sign = bit W-1, magnitude = W-1 bits
//  SAT     1  1: most-negative input clamps magnitude to all-ones; 0: magnitude = 0
//  CNT_W  16  width of saturation event counter, >= 1
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input word valid
//  in_ready   out  1        converter can accept input this cycle
//  tc         in   W        two's-complement input word
//  out_valid  out  1        output word valid
//  out_ready  in   1        downstream accepts output this cycle
//  sign       out  1        sign of output word (= tc[W-1])
//  sm         out  W-1      magnitude of output word
//  out_sat    out  1        output word came from the most-negative input
//  clr_cnt    in   1        synchronous clear of sat_cnt and sat_seen
//  sat_cnt    out  CNT_W    count of saturated words delivered (saturating)
//  sat_seen   out  1        sticky: at least one saturated word delivered
// BEHAVIOUR
//  - Reset (rst_n=0, async): both stage valids, sign, sm, out_sat, sat_cnt,
//    and sat_seen go to 0 immediately. in_ready = 1 from the first edge after release.
//  - Pipeline: two registered stages. S1 holds the raw tc word. S2 holds the
//    converted sign/sm/out_sat; out_valid = S2 valid.
//  - Stage advance: s2_take = !s2_v | out_ready; s1_take = !s1_v | (s1_v & s2_take).
//    in_ready = s1_take (combinational from out_ready; no storage beyond 2 words).
//  - Accept on in_valid & in_ready. Deliver on out_valid & out_ready.
//  - Latency: 2 cycles from accept to out_valid with out_ready held high.
//    Throughput 1 word/cycle. Order preserved; no drop or duplicate under any
//    pattern of in_valid/out_ready.
//  - While out_valid=1 & out_ready=0: sign, sm, out_sat hold stable.
//  - Conversion (S1 -> S2):
//      tc[W-1]=0           : sign=0, sm=tc[W-2:0], out_sat=0
//      tc[W-1]=1, rest!=0  : sign=1, sm=(~tc[W-2:0])+1 truncated to W-1, out_sat=0
//      tc = 1 followed by 0s: sign=1, out_sat=1, sm = SAT ? all-ones : 0
//  - Zero input gives sign=0, sm=0 (no negative zero ever produced).
//  - sat_cnt: +1 on each delivery with out_sat=1. Holds at 2^CNT_W-1 (no wrap).
//    sat_seen is set on the same event.
//  - clr_cnt=1: next edge sat_cnt=0, sat_seen=0. If a saturated delivery occurs
//    in the same cycle, clear wins (result 0/0). Clear does not affect the pipeline.
//  - Reset asserted mid-stream: in-flight words are discarded and no output is
//    produced for them after release.
//  - Outputs sign/sm/out_sat are don't-care when out_valid=0. They are driven 0
//    after reset until the first delivery.
// TESTING (W=12 unless noted; out_ready=1 unless noted)
//  1) tc=0x7FF,0x001,0x000 back-to-back -> after 2 cycles: (0,0x7FF),(0,0x001),(0,0x000)
//     on consecutive cycles, out_sat=0.
//  2) tc=0xFFF,0x801 -> (1,0x001),(1,0x7FF). tc=0x800 with SAT=1 -> (1,0x7FF,
//     out_sat=1); with SAT=0 -> (1,0x000,out_sat=1).
//  3) Stream 0x001..0x006 with in_valid=1 and out_ready=0 for cycles 3-5 ->
//     in_ready=0 once 2 words are held. All 6 are delivered in order with no gap
//     after out_ready returns.
//  4) CNT_W=2: deliver five 0x800 words -> sat_cnt 1,2,3,3,3; sat_seen=1.
//     Then clr_cnt in the same cycle as a sixth delivery -> sat_cnt=0, sat_seen=0.
//  5) Assert rst_n=0 asynchronously with 2 words in flight -> out_valid, sat_cnt,
//     and sat_seen drop to 0 without a clock edge. No stale word appears after release.
//  6) W=4 random sweep of all 16 codes under random in_valid/out_ready ->
//     scoreboard matches the conversion table, and order is preserved.

Source files
------------

// File: rtl/tc_sm_stream.sv
// -----------------------------------------------------------------------------
// tc_sm_stream
//   Pipelined two's-complement to sign-magnitude converter with a valid/ready
//   stream interface and a saturation event counter.
//
//   Stage S1 registers the raw input word. Stage S2 registers the converted
//   sign / magnitude / saturation flag, and that stage drives the outputs.
//   Backpressure ripples back combinationally, so in_ready depends on
//   out_ready. At most two words are held.
//
// Parameters
//   W      input word width (>= 2). The sign is bit W-1 and the magnitude is W-1 bits.
//   SAT    1: a most-negative input gives magnitude all-ones. 0: it gives magnitude 0.
//   CNT_W  width of the saturation event counter (>= 1)
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   input handshake. tc is the two's-complement word.
//   out_valid / out_ready output handshake. sign and sm are the converted word.
//   out_sat               set when the output word came from the most-negative input
//   clr_cnt               synchronous clear of sat_cnt and sat_seen
//   sat_cnt               counts saturated words delivered. It holds at its maximum.
//   sat_seen              sticky flag: at least one saturated word has been delivered
// -----------------------------------------------------------------------------
module tc_sm_stream #(
  parameter int W     = 12,
  parameter bit SAT   = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     tc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [W-2:0]     sm,
  output logic             out_sat,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             sat_seen
);

  localparam int MW = W - 1;

  // Stage S1: raw word
  logic          s1_v_q, s1_v_d;
  logic [W-1:0]  s1_tc_q, s1_tc_d;

  // Stage S2: converted word
  logic          s2_v_q, s2_v_d;
  logic          sign_q, sign_d;
  logic [MW-1:0] sm_q, sm_d;
  logic          sat_q, sat_d;

  // Saturation statistics
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;

  // Handshake
  logic s2_take, s1_take;
  logic deliver_sat;

  // Conversion of the word held in S1
  logic          cv_sign;
  logic          cv_sat;
  logic [MW-1:0] cv_rest;
  logic [MW-1:0] cv_sm;

  // S2 can load when it is empty or when its word leaves this cycle.
  // S1 can load when it is empty or when its word moves into S2.
  assign s2_take  = !s2_v_q || out_ready;
  assign s1_take  = !s1_v_q || s2_take;
  assign in_ready = s1_take;

  assign deliver_sat = s2_v_q && out_ready && sat_q;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch.
    // A path that leaves one unassigned would infer a latch.
    cv_rest = s1_tc_q[W-2:0];
    cv_sign = s1_tc_q[W-1];
    cv_sat  = cv_sign && (cv_rest == '0);
    cv_sm   = cv_rest;
    if (cv_sat) begin
      // 1 followed by zeros has no positive counterpart in W-1 bits.
      cv_sm = SAT ? '1 : '0;
    end else if (cv_sign) begin
      cv_sm = (~cv_rest) + MW'(1);
    end
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_tc_d = s1_tc_q;
    if (s1_take) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_tc_d = tc;
      end
    end
  end

  always_comb begin
    s2_v_d = s2_v_q;
    sign_d = sign_q;
    sm_d   = sm_q;
    sat_d  = sat_q;
    // Data moves only with a valid word, so a stalled or drained S2 keeps
    // its last value.
    if (s2_take) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        sign_d = cv_sign;
        sm_d   = cv_sm;
        sat_d  = cv_sat;
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    seen_d = seen_q;
    // Clear takes priority over a saturated delivery in the same cycle.
    if (clr_cnt) begin
      cnt_d  = '0;
      seen_d = 1'b0;
    end else if (deliver_sat) begin
      seen_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then sample their next values from the same edge, so evaluation order
  // does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      sign_q <= 1'b0;
      sm_q   <= '0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      sign_q <= sign_d;
      sm_q   <= sm_d;
      sat_q  <= sat_d;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end

  // NOTE: the S1 data register has no reset on purpose. Whether it holds
  // meaningful data is decided by s1_v_q alone. The S2 data does get a reset
  // because the outputs must read 0 after reset.
  always_ff @(posedge clk) begin
    s1_tc_q <= s1_tc_d;
  end

  assign out_valid = s2_v_q;
  assign sign      = sign_q;
  assign sm        = sm_q;
  assign out_sat   = sat_q;
  assign sat_cnt   = cnt_q;
  assign sat_seen  = seen_q;

endmodule

// File: tb/tb_tc_sm_stream.sv
// -----------------------------------------------------------------------------
// tb_tc_sm_stream
//   Directed bench for tc_sm_stream. It uses three instances:
//     A: W=12, SAT=1, CNT_W=2
//     B: W=12, SAT=0, CNT_W=16
//     C: W=4,  SAT=1, CNT_W=16
//   sel chooses which instance the shared drive signals control and which
//   instance's outputs appear on the m_* observation signals. The other
//   instances are held idle.
// -----------------------------------------------------------------------------
module tb_tc_sm_stream;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  int          sel;
  logic        d_valid;
  logic [11:0] d_tc;
  logic        d_ordy;
  logic        d_clr;

  // Instance A
  logic        iv_a, or_a, clr_a, ir_a, ov_a, sign_a, sat_a, seen_a;
  logic [10:0] sm_a;
  logic [1:0]  cnt_a;
  // Instance B
  logic        iv_b, or_b, clr_b, ir_b, ov_b, sign_b, sat_b, seen_b;
  logic [10:0] sm_b;
  logic [15:0] cnt_b;
  // Instance C
  logic        iv_c, or_c, clr_c, ir_c, ov_c, sign_c, sat_c, seen_c;
  logic [2:0]  sm_c;
  logic [15:0] cnt_c;

  assign iv_a  = (sel == 0) && d_valid;
  assign or_a  = (sel == 0) && d_ordy;
  assign clr_a = (sel == 0) && d_clr;
  assign iv_b  = (sel == 1) && d_valid;
  assign or_b  = (sel == 1) && d_ordy;
  assign clr_b = (sel == 1) && d_clr;
  assign iv_c  = (sel == 2) && d_valid;
  assign or_c  = (sel == 2) && d_ordy;
  assign clr_c = (sel == 2) && d_clr;

  tc_sm_stream #(.W(12), .SAT(1'b1), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .tc(d_tc),
    .out_valid(ov_a), .out_ready(or_a), .sign(sign_a), .sm(sm_a), .out_sat(sat_a),
    .clr_cnt(clr_a), .sat_cnt(cnt_a), .sat_seen(seen_a)
  );

  tc_sm_stream #(.W(12), .SAT(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .tc(d_tc),
    .out_valid(ov_b), .out_ready(or_b), .sign(sign_b), .sm(sm_b), .out_sat(sat_b),
    .clr_cnt(clr_b), .sat_cnt(cnt_b), .sat_seen(seen_b)
  );

  tc_sm_stream #(.W(4), .SAT(1'b1), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .tc(d_tc[3:0]),
    .out_valid(ov_c), .out_ready(or_c), .sign(sign_c), .sm(sm_c), .out_sat(sat_c),
    .clr_cnt(clr_c), .sat_cnt(cnt_c), .sat_seen(seen_c)
  );

  // Observation of the selected instance
  logic        m_ir, m_ov, m_sign, m_sat, m_seen;
  logic [10:0] m_sm;
  logic [15:0] m_cnt;

  always_comb begin
    m_ir = ir_a; m_ov = ov_a; m_sign = sign_a; m_sm = sm_a; m_sat = sat_a;
    m_cnt = {14'b0, cnt_a}; m_seen = seen_a;
    if (sel == 1) begin
      m_ir = ir_b; m_ov = ov_b; m_sign = sign_b; m_sm = sm_b; m_sat = sat_b;
      m_cnt = cnt_b; m_seen = seen_b;
    end else if (sel == 2) begin
      m_ir = ir_c; m_ov = ov_c; m_sign = sign_c; m_sm = {8'b0, sm_c}; m_sat = sat_c;
      m_cnt = cnt_c; m_seen = seen_c;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge. Outputs are observed 1 time unit
  // later, well clear of the next rising edge.
  task automatic step(input logic v, input logic [11:0] t, input logic ordy, input logic clr);
    @(negedge clk);
    d_valid = v;
    d_tc    = t;
    d_ordy  = ordy;
    d_clr   = clr;
    #1;
  endtask

  // Reference conversion for W=4, SAT=1, packed as {sign, sm[2:0], sat}.
  function automatic logic [4:0] conv4(input logic [3:0] t);
    int v;
    v = int'(t);
    if (t == 4'h8) return {1'b1, 3'b111, 1'b1};
    if (t[3]) return {1'b1, 3'(16 - v), 1'b0};
    return {1'b0, t[2:0], 1'b0};
  endfunction

  task automatic test_reset();
    sel = 0;
    #2;
    checks++;
    if ({m_ov, m_sign, m_sm, m_sat} !== 14'h0) begin
      errors++;
      $display("FAIL reset_out: got ov=%b sign=%b sm=%h sat=%b, want all 0", m_ov, m_sign, m_sm, m_sat);
    end
    checks++;
    if ({m_cnt, m_seen} !== 17'h0) begin
      errors++;
      $display("FAIL reset_cnt: got cnt=%0d seen=%b, want 0 0", m_cnt, m_seen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_ir !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", m_ir);
    end
  endtask

  task automatic test_positive();
    logic [11:0] vin [6];
    logic [10:0] vexp [3];
    vin  = '{12'h7FF, 12'h001, 12'h000, 12'h000, 12'h000, 12'h000};
    vexp = '{11'h7FF, 11'h001, 11'h000};
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      step(i < 3, vin[i], 1'b1, 1'b0);
      checks++;
      if (i >= 2 && i <= 4) begin
        if ({m_ov, m_sign, m_sm, m_sat} !== {1'b1, 1'b0, vexp[i-2], 1'b0}) begin
          errors++;
          $display("FAIL pos_word%0d: got ov=%b sign=%b sm=%h sat=%b, want 1 0 %h 0",
                   i - 2, m_ov, m_sign, m_sm, m_sat, vexp[i-2]);
        end
      end else if (m_ov !== 1'b0) begin
        errors++;
        $display("FAIL pos_idle_step%0d: got out_valid=%b, want 0", i, m_ov);
      end
    end
  endtask

  task automatic test_negative();
    logic [11:0] vin [4];
    logic [12:0] vexp [3];   // {sign, sm, sat}
    int n;
    for (int inst = 0; inst < 2; inst++) begin
      sel = inst;
      if (inst == 0) begin
        n = 3;
        vin  = '{12'hFFF, 12'h801, 12'h800, 12'h000};
        vexp = '{{1'b1, 11'h001, 1'b0}, {1'b1, 11'h7FF, 1'b0}, {1'b1, 11'h7FF, 1'b1}};
      end else begin
        n = 2;
        vin  = '{12'h800, 12'hFFF, 12'h000, 12'h000};
        vexp = '{{1'b1, 11'h000, 1'b1}, {1'b1, 11'h001, 1'b0}, 13'h0};
      end
      for (int i = 0; i < n + 2; i++) begin
        step(i < n, vin[i], 1'b1, 1'b0);
        if (i >= 2) begin
          checks++;
          if ({m_ov, m_sign, m_sm, m_sat} !== {1'b1, vexp[i-2]}) begin
            errors++;
            $display("FAIL neg_inst%0d_word%0d: got ov=%b sign=%b sm=%h sat=%b, want 1 %b %h %b",
                     inst, i - 2, m_ov, m_sign, m_sm, m_sat,
                     vexp[i-2][12], vexp[i-2][11:1], vexp[i-2][0]);
          end
        end
      end
      step(1'b0, 12'h0, 1'b1, 1'b0);
    end
    sel = 0;
  endtask

  task automatic test_backpressure();
    int next;
    int got [$];
    int dstep [$];
    int exp_step [6];
    logic ordy;
    exp_step = '{2, 6, 7, 8, 9, 10};
    next = 1;
    sel = 0;
    for (int s = 0; s < 14; s++) begin
      ordy = !(s >= 3 && s <= 5);
      step(next <= 6, 12'(next), ordy, 1'b0);
      if (s >= 3 && s <= 5) begin
        checks++;
        if (m_ir !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready_step%0d: got %b, want 0", s, m_ir);
        end
        checks++;
        if ({m_ov, m_sm} !== {1'b1, 11'h002}) begin
          errors++;
          $display("FAIL bp_hold_step%0d: got ov=%b sm=%h, want 1 002", s, m_ov, m_sm);
        end
      end
      if (d_valid && m_ir) next++;
      if (m_ov && d_ordy) begin
        got.push_back(int'(m_sm));
        dstep.push_back(s);
      end
    end
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d words, want 6", got.size());
    end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      checks++;
      if (got[k] != k + 1 || dstep[k] != exp_step[k]) begin
        errors++;
        $display("FAIL bp_word%0d: got value %0d at step %0d, want %0d at step %0d",
                 k, got[k], dstep[k], k + 1, exp_step[k]);
      end
    end
  endtask

  task automatic test_sat_counter();
    int exp_cnt;
    sel = 0;
    step(1'b0, 12'h0, 1'b1, 1'b1);
    step(1'b0, 12'h0, 1'b1, 1'b0);
    checks++;
    if ({m_cnt, m_seen} !== 17'h0) begin
      errors++;
      $display("FAIL sat_clear_initial: got cnt=%0d seen=%b, want 0 0", m_cnt, m_seen);
    end
    for (int s = 0; s < 9; s++) begin
      step(s < 6, 12'h800, 1'b1, s == 7);
      if (s >= 3 && s <= 7) begin
        exp_cnt = (s - 2 > 3) ? 3 : s - 2;
        checks++;
        if (m_cnt !== 16'(exp_cnt) || m_seen !== 1'b1) begin
          errors++;
          $display("FAIL sat_cnt_step%0d: got cnt=%0d seen=%b, want %0d 1", s, m_cnt, m_seen, exp_cnt);
        end
      end
      if (s == 7) begin
        checks++;
        if ({m_ov, m_sign, m_sm, m_sat} !== {1'b1, 1'b1, 11'h7FF, 1'b1}) begin
          errors++;
          $display("FAIL sat_sixth_word: got ov=%b sign=%b sm=%h sat=%b, want 1 1 7ff 1",
                   m_ov, m_sign, m_sm, m_sat);
        end
      end
      if (s == 8) begin
        checks++;
        if ({m_cnt, m_seen} !== 17'h0) begin
          errors++;
          $display("FAIL sat_clear_wins: got cnt=%0d seen=%b, want 0 0", m_cnt, m_seen);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    sel = 0;
    step(1'b1, 12'h800, 1'b1, 1'b0);
    step(1'b1, 12'h800, 1'b1, 1'b0);
    step(1'b1, 12'h123, 1'b1, 1'b0);
    step(1'b1, 12'h456, 1'b1, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    checks++;
    if ({m_ov, m_sm, m_cnt, m_seen} !== {1'b1, 11'h123, 16'd2, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_pre: got ov=%b sm=%h cnt=%0d seen=%b, want 1 123 2 1",
               m_ov, m_sm, m_cnt, m_seen);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_ov, m_cnt, m_seen} !== 18'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got ov=%b cnt=%0d seen=%b, want 0 0 0", m_ov, m_cnt, m_seen);
    end
    checks++;
    if ({m_sign, m_sm, m_sat} !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid_data: got sign=%b sm=%h sat=%b, want 0 0 0", m_sign, m_sm, m_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int s = 0; s < 6; s++) begin
      step(1'b0, 12'h000, 1'b1, 1'b0);
      if (m_ov) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rst_mid_stale: got %0d stale outputs, want 0", stale);
    end
  endtask

  task automatic test_w4_sweep();
    logic [3:0] codes [16];
    logic [3:0] sb [$];
    logic [3:0] t;
    logic [3:0] tmp;
    logic [4:0] e;
    int j;
    int fed;
    int delivered;
    sel = 2;
    for (int i = 0; i < 16; i++) codes[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = codes[i]; codes[i] = codes[j]; codes[j] = tmp;
    end
    fed = 0;
    delivered = 0;
    for (int s = 0; s < 600 && delivered < 16; s++) begin
      step((fed < 16) && ($urandom_range(0, 3) != 0),
           {8'h0, codes[(fed < 16) ? fed : 0]},
           $urandom_range(0, 3) != 0, 1'b0);
      if (d_valid && m_ir) begin
        sb.push_back(codes[fed]);
        fed++;
      end
      if (m_ov && d_ordy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL w4_spurious: delivery with no word outstanding, got sm=%h", m_sm);
        end else begin
          t = sb.pop_front();
          e = conv4(t);
          if ({m_sign, m_sm[2:0], m_sat} !== e) begin
            errors++;
            $display("FAIL w4_code_%h: got sign=%b sm=%h sat=%b, want %b %h %b",
                     t, m_sign, m_sm[2:0], m_sat, e[4], e[3:1], e[0]);
          end
        end
        delivered++;
      end
    end
    checks++;
    if (delivered != 16) begin
      errors++;
      $display("FAIL w4_count: got %0d deliveries, want 16", delivered);
    end
    step(1'b0, 12'h0, 1'b0, 1'b0);
    sel = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    sel     = 0;
    d_valid = 1'b0;
    d_tc    = 12'h0;
    d_ordy  = 1'b0;
    d_clr   = 1'b0;
    test_reset();
    test_positive();
    test_negative();
    test_backpressure();
    test_sat_counter();
    test_reset_midstream();
    test_w4_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
